// File: rtl/latency_lock.sv
// latency_lock: histograms one-hot loop-delay flags over a fixed window and
// reports the dominant loop latency, a lock indication and the miss count.
module latency_lock #(
  parameter int SETTLE = 6,
  parameter int WINDOW = 64,
  parameter int CNT_W  = 7,
  parameter int THRESH = 48
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_diff,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_valid,
  output logic [1:0]       o_lat,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_miss
);

  localparam int               SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;
  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t           state;
  logic [SET_W-1:0] settle_tmr;
  logic [CNT_W-1:0] win_tmr;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] bucket [4];
  logic [1:0]       best_idx;
  logic [CNT_W-1:0] best_cnt;

  // Strict greater-than keeps the lowest index on ties (shortest latency wins).
  always_comb begin
    best_idx = 2'd0;
    best_cnt = bucket[0];
    for (int i = 1; i < 4; i++) begin
      if (bucket[i] > best_cnt) begin
        best_idx = 2'(i);
        best_cnt = bucket[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      settle_tmr <= '0;
      win_tmr    <= '0;
      miss_cnt   <= '0;
      for (int i = 0; i < 4; i++) bucket[i] <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_valid    <= 1'b0;
      o_lat      <= 2'd0;
      o_locked   <= 1'b0;
      o_count    <= '0;
      o_miss     <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            for (int i = 0; i < 4; i++) bucket[i] <= '0;
            miss_cnt   <= '0;
            o_valid    <= 1'b0;
            o_locked   <= 1'b0;
            o_lat      <= 2'd0;
            o_count    <= '0;
            o_miss     <= '0;
            settle_tmr <= SET_LOAD;
            win_tmr    <= WIN_LOAD;
            o_busy     <= 1'b1;
            state      <= (SETTLE == 0) ? S_MEASURE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_tmr == '0) state <= S_MEASURE;
          else                  settle_tmr <= settle_tmr - SET_W'(1);
        end
        S_MEASURE: begin
          // Anything that is not exactly one-hot counts as a miss.
          case (i_diff)
            4'b0001: bucket[0] <= bucket[0] + CNT_W'(1);
            4'b0010: bucket[1] <= bucket[1] + CNT_W'(1);
            4'b0100: bucket[2] <= bucket[2] + CNT_W'(1);
            4'b1000: bucket[3] <= bucket[3] + CNT_W'(1);
            default: miss_cnt  <= miss_cnt + CNT_W'(1);
          endcase
          if (win_tmr == '0) state <= S_EVAL;
          else               win_tmr <= win_tmr - CNT_W'(1);
        end
        S_EVAL: begin
          o_lat    <= best_idx;
          o_count  <= best_cnt;
          o_miss   <= miss_cnt;
          o_locked <= (best_cnt >= THRESH_C);
          o_valid  <= 1'b1;
          o_done   <= 1'b1;
          o_busy   <= 1'b0;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latency_lock.sv
// Self-checking bench for latency_lock: table-driven windows, randomized
// windows against a histogram model, plus reset and restart sequences.
module tb_latency_lock;

  localparam int SETTLE = 6;
  localparam int WINDOW = 64;
  localparam int CNT_W  = 7;
  localparam int THRESH = 48;
  localparam int LIMIT  = 200;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [3:0]       i_diff;
  logic             o_busy;
  logic             o_done;
  logic             o_valid;
  logic [1:0]       o_lat;
  logic             o_locked;
  logic [CNT_W-1:0] o_count;
  logic [CNT_W-1:0] o_miss;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] win_data [WINDOW];

  typedef struct {
    string      name;
    int         n_a;
    logic [3:0] a;
    int         n_b;
    logic [3:0] b;
    logic [3:0] rest;
    logic [3:0] fill;
    int         restart_k;
    int         lat;
    int         cnt;
    int         miss;
    int         locked;
  } vec_t;

  vec_t vecs [7];

  always #5 i_clk = ~i_clk;

  latency_lock #(
    .SETTLE(SETTLE),
    .WINDOW(WINDOW),
    .CNT_W (CNT_W),
    .THRESH(THRESH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_diff  (i_diff),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_valid (o_valid),
    .o_lat   (o_lat),
    .o_locked(o_locked),
    .o_count (o_count),
    .o_miss  (o_miss)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Histogram by delay bucket, pick the largest with ties to the shortest delay.
  task automatic model(output int lat, output int cnt, output int miss, output int locked);
    int         hist [4];
    logic [3:0] one;
    one  = 4'b0001;
    miss = 0;
    for (int b = 0; b < 4; b++) hist[b] = 0;
    foreach (win_data[i]) begin
      if ($countones(win_data[i]) == 1) begin
        for (int b = 0; b < 4; b++)
          if (win_data[i] == (one << b)) hist[b]++;
      end else begin
        miss++;
      end
    end
    lat = 0;
    cnt = hist[0];
    for (int b = 1; b < 4; b++)
      if (hist[b] > cnt) begin
        lat = b;
        cnt = hist[b];
      end
    locked = (cnt >= THRESH) ? 1 : 0;
  endtask

  // Starts a measurement and feeds i_diff edge by edge; done_at is the edge
  // index (accepting edge = 0) at which o_done was first seen, or -1.
  task automatic applyStimulus(input logic [3:0] fill, input int restart_k, output int done_at);
    done_at = -1;
    @(negedge i_clk);
    i_start = 1'b1;
    i_diff  = fill;
    @(negedge i_clk);
    i_start = 1'b0;
    checkOutput("start valid dropped", int'(o_valid), 0);
    checkOutput("start busy", int'(o_busy), 1);
    for (int k = 1; k <= LIMIT; k++) begin
      if (k <= SETTLE)               i_diff = fill;
      else if (k <= SETTLE + WINDOW) i_diff = win_data[k-SETTLE-1];
      else                           i_diff = 4'($urandom_range(0, 15));
      i_start = (k == restart_k);
      @(negedge i_clk);
      if (o_done) begin
        done_at = k;
        break;
      end
    end
    i_start = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [3:0] fill, input int restart_k,
                             input int lat, input int cnt, input int miss, input int locked);
    int done_at;
    applyStimulus(fill, restart_k, done_at);
    checkOutput({name, " done latency"}, done_at, SETTLE + WINDOW + 1);
    checkOutput({name, " o_lat"}, int'(o_lat), lat);
    checkOutput({name, " o_count"}, int'(o_count), cnt);
    checkOutput({name, " o_miss"}, int'(o_miss), miss);
    checkOutput({name, " o_locked"}, int'(o_locked), locked);
    checkOutput({name, " o_valid"}, int'(o_valid), 1);
    checkOutput({name, " o_busy"}, int'(o_busy), 0);
    @(negedge i_clk);
    checkOutput({name, " done pulse width"}, int'(o_done), 0);
    checkOutput({name, " valid held"}, int'(o_valid), 1);
  endtask

  task automatic buildWindow(input vec_t v);
    for (int i = 0; i < WINDOW; i++) begin
      if (i < v.n_a)              win_data[i] = v.a;
      else if (i < v.n_a + v.n_b) win_data[i] = v.b;
      else                        win_data[i] = v.rest;
    end
  endtask

  task automatic idleCheck(input string name, input int cycles);
    int busy_seen = 0;
    int done_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      i_diff = 4'($urandom_range(0, 15));
      @(negedge i_clk);
      if (o_busy) busy_seen++;
      if (o_done) done_seen++;
    end
    checkOutput({name, " busy cycles"}, busy_seen, 0);
    checkOutput({name, " done pulses"}, done_seen, 0);
  endtask

  initial begin
    int lat, cnt, miss, locked;

    vecs[0] = '{"steady 2-cycle", 64, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0010, 0, 1, 64, 0, 1};
    vecs[1] = '{"mixed 30/30/4", 30, 4'b0100, 30, 4'b1000, 4'b0000, 4'b0001, SETTLE + 30, 2, 30, 4, 0};
    vecs[2] = '{"tie 32/32", 32, 4'b0001, 32, 4'b1000, 4'b0000, 4'b0100, 0, 0, 32, 0, 0};
    vecs[3] = '{"illegal codes", 10, 4'b0110, 54, 4'b0001, 4'b0001, 4'b1000, 0, 0, 54, 10, 1};
    vecs[4] = '{"all miss", 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0, 0, 64, 0};
    vecs[5] = '{"thresh exact", 48, 4'b1000, 16, 4'b1111, 4'b1111, 4'b0000, 0, 3, 48, 16, 1};
    vecs[6] = '{"thresh minus one", 47, 4'b0100, 17, 4'b0001, 4'b0001, 4'b1000, 0, 2, 47, 0, 0};

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_diff  = 4'b0000;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("reset o_valid", int'(o_valid), 0);
    checkOutput("reset o_busy", int'(o_busy), 0);

    buildWindow(vecs[0]);
    runAndCheck(vecs[0].name, vecs[0].fill, vecs[0].restart_k,
                vecs[0].lat, vecs[0].cnt, vecs[0].miss, vecs[0].locked);

    // Asynchronous reset between edges must clear results without a clock.
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("async reset o_valid", int'(o_valid), 0);
    checkOutput("async reset o_lat", int'(o_lat), 0);
    checkOutput("async reset o_count", int'(o_count), 0);
    checkOutput("async reset o_locked", int'(o_locked), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    idleCheck("idle", 100);

    foreach (vecs[v]) begin
      buildWindow(vecs[v]);
      runAndCheck(vecs[v].name, vecs[v].fill, vecs[v].restart_k,
                  vecs[v].lat, vecs[v].cnt, vecs[v].miss, vecs[v].locked);
    end

    for (int r = 0; r < 6; r++) begin
      int fav;
      fav = $urandom_range(0, 3);
      for (int i = 0; i < WINDOW; i++) begin
        if ($urandom_range(0, 9) < 6) win_data[i] = 4'b0001 << fav;
        else                          win_data[i] = 4'($urandom_range(0, 15));
      end
      model(lat, cnt, miss, locked);
      runAndCheck($sformatf("random %0d", r), 4'($urandom_range(0, 15)), 0, lat, cnt, miss, locked);
    end

    // Reset 20 cycles into MEASURE aborts with no o_done.
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 1; k <= SETTLE + 20; k++) begin
      i_diff = 4'b0001;
      @(negedge i_clk);
    end
    checkOutput("pre-abort busy", int'(o_busy), 1);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("abort o_busy", int'(o_busy), 0);
    checkOutput("abort o_miss", int'(o_miss), 0);
    checkOutput("abort o_count", int'(o_count), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    idleCheck("post-abort", 80);

    buildWindow(vecs[3]);
    runAndCheck("after abort", vecs[3].fill, 0, vecs[3].lat, vecs[3].cnt, vecs[3].miss, vecs[3].locked);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
